sha_msg_ctrl: RTL and testbench

SHA_MSG_CTRL -- requirements
Module: sha_msg_ctrl

---
 rtl/sha_msg_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sha_msg_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha_msg_ctrl.sv
`default_nettype none
// ============================================================================
// sha_msg_ctrl : SHA-2 message padder/sequencer feeding a word-per-cycle core
// Revision 1.0
// ============================================================================
module sha_msg_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [1:0]  in_bytes,
  output logic        core_word_valid,
  output logic [31:0] core_word,
  output logic        core_first_blk,
  output logic        core_blk_start,
  input  logic        core_done,
  output logic        busy,
  output logic        msg_done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PAD  = 3'd2,
    ZERO = 3'd3,
    LENH = 3'd4,
    LENL = 3'd5,
    WAIT = 3'd6,
    FIN  = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_idx;
  logic [63:0] r_len;
  logic        r_first;
  logic        r_pad_pend;
  logic        r_msg_end;
  logic        r_len_done;
  logic        r_word_valid;
  logic        r_blk_start;
  logic [31:0] r_word;

  logic        w_accept;
  logic        w_emit;
  logic [31:0] w_word;
  logic [2:0]  w_nbytes;
  logic        w_set_pad;
  logic        w_set_end;
  logic        w_set_len_done;

  // Where to go after the word that carries the 0x80 marker at index idx.
  function automatic state_t after_marker(input logic [3:0] idx);
    if (idx == 4'd15)      return WAIT;
    else if (idx == 4'd13) return LENH;
    else                   return ZERO;
  endfunction

  assign in_ready = (r_state == IDLE) || (r_state == LOAD);
  assign w_accept = in_valid && in_ready;
  assign w_nbytes = (in_last && (in_bytes != 2'd0)) ? {1'b0, in_bytes} : 3'd4;

  always_comb begin
    w_next         = r_state;
    w_emit         = 1'b0;
    w_word         = 32'h0;
    w_set_pad      = 1'b0;
    w_set_end      = 1'b0;
    w_set_len_done = 1'b0;
    case (r_state)
      IDLE, LOAD: begin
        if (w_accept) begin
          w_emit = 1'b1;
          w_word = in_data;
          if (in_last) begin
            w_set_end = 1'b1;
            case (in_bytes)
              2'd1:    w_word = {in_data[31:24], 8'h80, 16'h0000};
              2'd2:    w_word = {in_data[31:16], 8'h80, 8'h00};
              2'd3:    w_word = {in_data[31:8], 8'h80};
              default: w_word = in_data;
            endcase
            if (in_bytes != 2'd0) begin
              w_next = after_marker(r_idx);
            end else if (r_idx == 4'd15) begin
              // Marker word must open the next block.
              w_next    = WAIT;
              w_set_pad = 1'b1;
            end else begin
              w_next = PAD;
            end
          end else begin
            w_next = (r_idx == 4'd15) ? WAIT : LOAD;
          end
        end
      end
      PAD: begin
        w_emit = 1'b1;
        w_word = 32'h8000_0000;
        w_next = after_marker(r_idx);
      end
      ZERO: begin
        w_emit = 1'b1;
        if (r_idx == 4'd13)      w_next = LENH;
        else if (r_idx == 4'd15) w_next = WAIT;
      end
      LENH: begin
        w_emit = 1'b1;
        w_word = r_len[63:32];
        w_next = LENL;
      end
      LENL: begin
        w_emit         = 1'b1;
        w_word         = r_len[31:0];
        w_set_len_done = 1'b1;
        w_next         = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          if (r_len_done)      w_next = FIN;
          else if (r_pad_pend) w_next = PAD;
          else if (r_msg_end)  w_next = ZERO;
          else                 w_next = LOAD;
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= 4'd0;
      r_len        <= 64'd0;
      r_first      <= 1'b0;
      r_pad_pend   <= 1'b0;
      r_msg_end    <= 1'b0;
      r_len_done   <= 1'b0;
      r_word_valid <= 1'b0;
      r_blk_start  <= 1'b0;
      r_word       <= 32'h0;
    end else begin
      r_word_valid <= w_emit;
      r_blk_start  <= w_emit && (r_idx == 4'd0);
      if (w_emit) begin
        r_word <= w_word;
        r_idx  <= r_idx + 4'd1;
      end
      if (w_accept) r_len <= r_len + {58'd0, w_nbytes, 3'b000};
      if (w_accept && (r_state == IDLE)) r_first <= 1'b1;
      if ((r_state == WAIT) && core_done) r_first <= 1'b0;
      if (w_set_end)      r_msg_end  <= 1'b1;
      if (w_set_pad)      r_pad_pend <= 1'b1;
      if (r_state == PAD) r_pad_pend <= 1'b0;
      if (w_set_len_done) r_len_done <= 1'b1;
      if (r_state == FIN) begin
        r_len      <= 64'd0;
        r_msg_end  <= 1'b0;
        r_len_done <= 1'b0;
        r_first    <= 1'b0;
      end
    end
  end

  assign core_word_valid = r_word_valid;
  assign core_word       = r_word;
  assign core_blk_start  = r_blk_start;
  assign core_first_blk  = r_first;
  assign busy            = (r_state != IDLE) && (r_state != FIN);
  assign msg_done        = (r_state == FIN);

endmodule
`default_nettype wire

// File: tb/tb_sha_msg_ctrl.sv
`default_nettype none
// tb_sha_msg_ctrl : randomized bench with a byte-level SHA padding model.
module tb_sha_msg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        in_last = 1'b0;
  logic [1:0]  in_bytes = 2'd0;
  logic        core_word_valid;
  logic [31:0] core_word;
  logic        core_first_blk;
  logic        core_blk_start;
  logic        core_done = 1'b0;
  logic        busy;
  logic        msg_done;

  always #5 clk = ~clk;

  sha_msg_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
    .core_word_valid(core_word_valid), .core_word(core_word),
    .core_first_blk(core_first_blk), .core_blk_start(core_blk_start),
    .core_done(core_done), .busy(busy), .msg_done(msg_done)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] msg [0:63];
  logic [31:0] exp_q [$];
  bit          exp_fb [$];
  int          cnt = 0;
  int          delay = 0;
  bit          pending = 0;
  bit          expect_done = 0;
  int          msgs_done = 0;
  logic [31:0] cap [0:63];
  int          cap_pos = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Standard SHA-2 padding computed on a byte stream, then cut into words.
  task automatic build_expected(input int n, input logic [1:0] lb);
    logic [7:0]  b [$];
    logic [63:0] bits;
    int          k;
    for (int i = 0; i < n; i++) begin
      k = (i == n - 1 && lb != 2'd0) ? int'(lb) : 4;
      for (int j = 0; j < k; j++) b.push_back(msg[i][31 - 8*j -: 8]);
    end
    bits = 64'(b.size()) * 64'd8;
    b.push_back(8'h80);
    while (b.size() % 64 != 56) b.push_back(8'h00);
    for (int j = 7; j >= 0; j--) b.push_back(bits[8*j +: 8]);
    for (int w = 0; w < b.size() / 4; w++) begin
      exp_q.push_back({b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]});
      exp_fb.push_back(w < 16);
    end
  endtask

  // Core model and output checker.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_valid", core_word_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_msg_done", msg_done, 0);
      chk("rst_first_blk", core_first_blk, 0);
      chk("rst_blk_start", core_blk_start, 0);
      chk("rst_word", core_word, 0);
      exp_q.delete();
      exp_fb.delete();
      cnt = 0;
      pending = 0;
      expect_done = 0;
      core_done = 1'b1;
    end else begin
      chk("msg_done", msg_done, expect_done);
      expect_done = 0;
      if (msg_done) begin
        msgs_done++;
        chk("busy_at_done", busy, 0);
      end
      core_done = 1'b0;
      if (core_word_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_word: actual=%0h required=none", core_word);
        end else begin
          chk("core_word", core_word, exp_q.pop_front());
          chk("first_blk", core_first_blk, exp_fb.pop_front());
          chk("blk_start", core_blk_start, cnt == 0);
          chk("busy", busy, 1);
        end
        if (cap_pos < 64) begin
          cap[cap_pos] = core_word;
          cap_pos++;
        end
        cnt++;
        if (cnt == 16) begin
          pending = 1;
          delay = $urandom_range(0, 3);
        end
      end
      if (pending) begin
        chk("in_ready_wait", in_ready, 0);
        if (delay == 0) begin
          core_done = 1'b1;
          pending = 0;
          cnt = 0;
          expect_done = (exp_q.size() == 0);
        end else begin
          delay--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        core_done = 1'b1;
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input bit last, input logic [1:0] nb);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL in_ready_timeout: actual=0 required=1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = 2'($urandom);
    in_data  = $urandom;
  endtask

  task automatic send_msg(input int n, input logic [1:0] lb, input bit gaps);
    int start;
    int guard;
    build_expected(n, lb);
    cap_pos = 0;
    start = msgs_done;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_word(msg[i], i == n - 1, (i == n - 1) ? lb : 2'($urandom));
    end
    guard = 0;
    while (msgs_done == start && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("msg_completed", msgs_done - start, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    msg[0] = 32'h6162_6300;
    send_msg(1, 2'd3, 0);
    chk("abc_w0", cap[0], 32'h6162_6380);
    chk("abc_w1", cap[1], 32'h0);
    chk("abc_w14", cap[14], 32'h0);
    chk("abc_w15", cap[15], 32'h18);

    for (int i = 0; i < 13; i++) msg[i] = $urandom;
    send_msg(13, 2'd0, 0);
    chk("w13_pad", cap[13], 32'h8000_0000);
    chk("w13_len_hi", cap[14], 32'h0);
    chk("w13_len_lo", cap[15], 32'h1A0);

    for (int i = 0; i < 14; i++) msg[i] = $urandom;
    send_msg(14, 2'd0, 0);
    chk("w14_pad", cap[14], 32'h8000_0000);
    chk("w14_zero15", cap[15], 32'h0);
    chk("w14_blk2_zero", cap[29], 32'h0);
    chk("w14_len_lo", cap[31], 32'h1C0);

    for (int i = 0; i < 20; i++) msg[i] = $urandom;
    send_msg(20, 2'd0, 1);
    chk("w20_pass", cap[19], msg[19]);
    chk("w20_pad", cap[20], 32'h8000_0000);
    chk("w20_len_lo", cap[31], 32'h280);

    // Reset while the controller is emitting padding zeros.
    msg[0] = 32'h6162_6300;
    build_expected(1, 2'd3);
    send_word(msg[0], 1, 2'd3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_valid", core_word_valid, 0);
    chk("post_rst_busy", busy, 0);
    send_msg(1, 2'd3, 0);
    chk("abc2_w0", cap[0], 32'h6162_6380);
    chk("abc2_w15", cap[15], 32'h18);

    repeat (30) begin
      int n;
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) msg[i] = $urandom;
      send_msg(n, 2'($urandom), 1'($urandom));
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
